uart_addr_node: RTL
===================

UART_ADDR_NODE -- requirements
Module: uart_addr_node

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208, clock cycles per UART bit (50 MHz / 9600 baud); minimum 4.
REQ-002 Parameter DATA_BITS, default 8, frame payload width, from 5 to 9.
REQ-003 Parameter ID_BITS, default 2, width of the destination ID field (payload MSBs); less than DATA_BITS.
REQ-004 Parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 tx_start  in  1  request to send tx_data; sampled only in TX IDLE.
REQ-008 tx_data  in  DATA_BITS  payload to transmit, MSBs = destination ID.
REQ-009 Tx  out  1  serial output line, idle high.
REQ-010 tx_busy  out  1  high while a frame is being transmitted.
REQ-011 Rx  in  1  serial input line, asynchronous to clk.
REQ-012 my_id  in  ID_BITS  this node's address.
REQ-013 rx_data  out  DATA_BITS  last accepted payload, held until the next accept.
REQ-014 rx_valid  out  1  one-cycle pulse: rx_data updated.
REQ-015 rx_err  out  1  one-cycle pulse: framing or parity error.
REQ-016 rx_drop  out  1  one-cycle pulse: good frame addressed elsewhere.

Function
REQ-017 TX FSM states SHALL be IDLE, START, DATA, PAR, STOP, each bit state lasting exactly CLKS_PER_BIT cycles; PAR is skipped when PARITY=0.
REQ-018 tx_start=1 in IDLE SHALL latch tx_data and enter START on the next edge; tx_busy SHALL rise with START and fall on the cycle after STOP completes.
REQ-019 tx_start while tx_busy=1 SHALL be ignored; tx_data changes after latching SHALL not affect the frame.
REQ-020 Tx SHALL send start bit 0, DATA_BITS LSB first, the parity bit if enabled, then stop bit 1; Tx SHALL be 1 in IDLE.
REQ-021 Rx SHALL pass through a 2-flop synchroniser before use.
REQ-022 RX FSM states SHALL be IDLE, START, DATA, PAR, STOP; a 1-to-0 transition of synchronised Rx in IDLE SHALL enter START.
REQ-023 START SHALL re-sample Rx at CLKS_PER_BIT/2 (integer division); Rx=1 there is a glitch and SHALL return to IDLE with no output pulse.
REQ-024 Subsequent bits SHALL be sampled every CLKS_PER_BIT cycles after the start mid-point; data is assembled LSB first.
REQ-025 Parity SHALL be checked against PARITY mode; the stop sample SHALL be 1, otherwise a framing error occurs.
REQ-026 At the stop-bit sample, exactly one of rx_valid, rx_err, or rx_drop SHALL pulse on the next cycle: rx_err on any error, else rx_valid if payload ID = my_id or ID = all-ones (broadcast), else rx_drop.
REQ-027 rx_data SHALL update only together with rx_valid.
REQ-028 After the stop sample the RX FSM SHALL return to IDLE immediately, so a new start edge is detected within the same stop bit.
REQ-029 TX and RX SHALL operate independently and concurrently; Tx looped back to Rx SHALL deliver its own addressed frames.
REQ-030 Bit counters SHALL be sized by $clog2 of their parameters; no counter may wrap inside a frame.

Reset
REQ-031 reset=1 SHALL force both FSMs to IDLE, with Tx=1, tx_busy=0, rx_data=0, rx_valid=rx_err=rx_drop=0, all counters 0, and synchroniser flops 1.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, TX waits for tx_start and RX waits for a fresh falling edge.

Verification (bench: CLKS_PER_BIT=16, DATA_BITS=8, ID_BITS=2)
REQ-033 PARITY=0, my_id=2'b01, tx_data=8'h5A, Tx looped to Rx -> Tx shows 0,0,1,0,1,1,0,1,0,1 at 16-cycle spacing; tx_busy high for 160 cycles; rx_valid pulse with rx_data=8'h5A.
REQ-034 my_id=2'b01, Rx frame 8'h9A (ID 10) -> rx_drop pulse; rx_data unchanged. Rx frame 8'hC3 (ID 11, broadcast) -> rx_valid with rx_data=8'hC3.
REQ-035 PARITY=1, frame 8'h47 sent with parity bit 1 (wrong) -> rx_err pulse; the same frame with parity 0 -> rx_valid.
REQ-036 Stop bit driven 0 -> rx_err. Rx low for 5 cycles only -> no pulse and RX back in IDLE.
REQ-037 Second tx_start pulsed mid-frame -> ignored; reset asserted at data bit 3 -> Tx=1 and tx_busy=0 immediately, with no rx pulse.
REQ-038 Two back-to-back frames with no idle gap (next start directly after stop) -> two rx_valid pulses with correct data.

Source files
------------

// File: rtl/uart_addr_node.sv
// Addressed UART node: an independent transmitter and receiver sharing one clock.
// Received frames carry a destination ID in their payload MSBs; only frames for this node (or broadcast) are delivered.
module uart_addr_node #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int ID_BITS      = 2,
    parameter int PARITY       = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 Tx,
    output logic                 tx_busy,
    input  logic                 Rx,
    input  logic [ID_BITS-1:0]   my_id,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_err,
    output logic                 rx_drop
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    // Parity bit that makes the frame's one-count even (mode 1) or odd (mode 2).
    function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
        return (^d) ^ (PARITY == 2);
    endfunction

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t                 tx_state_reg;
    logic [CNT_W-1:0]       tx_cnt_reg;
    logic [BIT_W-1:0]       tx_bit_reg;
    logic [DATA_BITS-1:0]   tx_shift_reg;
    logic                   tx_par_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_reg <= IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            tx_par_reg   <= 1'b0;
            Tx           <= 1'b1;
            tx_busy      <= 1'b0;
        end else begin
            case (tx_state_reg)
                IDLE: begin
                    Tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    if (tx_start) begin
                        tx_shift_reg <= tx_data;
                        tx_par_reg   <= par_bit(tx_data);
                        tx_cnt_reg   <= '0;
                        tx_bit_reg   <= '0;
                        Tx           <= 1'b0;
                        tx_busy      <= 1'b1;
                        tx_state_reg <= START;
                    end
                end
                START: begin
                    if (tx_cnt_reg == BIT_END) begin
                        tx_cnt_reg   <= '0;
                        tx_bit_reg   <= '0;
                        Tx           <= tx_shift_reg[0];
                        tx_shift_reg <= tx_shift_reg >> 1;
                        tx_state_reg <= DATA;
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (tx_cnt_reg == BIT_END) begin
                        tx_cnt_reg <= '0;
                        if (tx_bit_reg == BIT_LAST) begin
                            if (PARITY != 0) begin
                                Tx           <= tx_par_reg;
                                tx_state_reg <= PAR;
                            end else begin
                                Tx           <= 1'b1;
                                tx_state_reg <= STOP;
                            end
                        end else begin
                            tx_bit_reg   <= tx_bit_reg + BIT_W'(1);
                            Tx           <= tx_shift_reg[0];
                            tx_shift_reg <= tx_shift_reg >> 1;
                        end
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + CNT_W'(1);
                    end
                end
                PAR: begin
                    if (tx_cnt_reg == BIT_END) begin
                        tx_cnt_reg   <= '0;
                        Tx           <= 1'b1;
                        tx_state_reg <= STOP;
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (tx_cnt_reg == BIT_END) begin
                        tx_cnt_reg   <= '0;
                        tx_busy      <= 1'b0;
                        tx_state_reg <= IDLE;
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    tx_state_reg <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    state_t                 rx_state_reg;
    logic [CNT_W-1:0]       rx_cnt_reg;
    logic [BIT_W-1:0]       rx_bit_reg;
    logic [DATA_BITS-1:0]   rx_shift_reg;
    logic                   rx_par_err_reg;
    logic                   rx_meta_reg;
    logic                   rx_sync_reg;
    logic                   rx_prev_reg;
    logic [ID_BITS-1:0]     rx_id;
    logic                   rx_for_me;

    assign rx_id     = rx_shift_reg[DATA_BITS-1 -: ID_BITS];
    assign rx_for_me = (rx_id == my_id) || (&rx_id);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_reg    <= 1'b1;
            rx_sync_reg    <= 1'b1;
            rx_prev_reg    <= 1'b1;
            rx_state_reg   <= IDLE;
            rx_cnt_reg     <= '0;
            rx_bit_reg     <= '0;
            rx_shift_reg   <= '0;
            rx_par_err_reg <= 1'b0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            rx_err         <= 1'b0;
            rx_drop        <= 1'b0;
        end else begin
            rx_meta_reg <= Rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
            rx_valid    <= 1'b0;
            rx_err      <= 1'b0;
            rx_drop     <= 1'b0;
            case (rx_state_reg)
                IDLE: begin
                    rx_cnt_reg <= '0;
                    if (rx_prev_reg && !rx_sync_reg) begin
                        rx_state_reg <= START;
                    end
                end
                START: begin
                    // A line already back high at mid start bit was only a glitch.
                    if (rx_cnt_reg == HALF_END) begin
                        rx_cnt_reg     <= '0;
                        rx_bit_reg     <= '0;
                        rx_par_err_reg <= 1'b0;
                        rx_state_reg   <= rx_sync_reg ? IDLE : DATA;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (rx_cnt_reg == BIT_END) begin
                        rx_cnt_reg   <= '0;
                        rx_shift_reg <= {rx_sync_reg, rx_shift_reg[DATA_BITS-1:1]};
                        if (rx_bit_reg == BIT_LAST) begin
                            rx_state_reg <= (PARITY != 0) ? PAR : STOP;
                        end else begin
                            rx_bit_reg <= rx_bit_reg + BIT_W'(1);
                        end
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + CNT_W'(1);
                    end
                end
                PAR: begin
                    if (rx_cnt_reg == BIT_END) begin
                        rx_cnt_reg     <= '0;
                        rx_par_err_reg <= (rx_sync_reg != par_bit(rx_shift_reg));
                        rx_state_reg   <= STOP;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + CNT_W'(1);
                    end
                end
                STOP: begin
                    // Back to IDLE at mid stop bit so a following start edge is not missed.
                    if (rx_cnt_reg == BIT_END) begin
                        rx_cnt_reg   <= '0;
                        rx_state_reg <= IDLE;
                        if (!rx_sync_reg || rx_par_err_reg) begin
                            rx_err <= 1'b1;
                        end else if (rx_for_me) begin
                            rx_valid <= 1'b1;
                            rx_data  <= rx_shift_reg;
                        end else begin
                            rx_drop <= 1'b1;
                        end
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    rx_state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
